// File: rtl/can_frame_sequencer_pkg.sv
// can_frame_sequencer_pkg: shared CAN field codes, field lengths and data-length helper
package can_frame_sequencer_pkg;
  typedef enum logic [4:0] {
    FLD_INTEG, FLD_IDLE, FLD_ID_A, FLD_RTR_SRR, FLD_IDE, FLD_ID_B, FLD_RTR_EXT, FLD_R1,
    FLD_R0, FLD_DLC, FLD_DATA, FLD_CRC, FLD_CRC_D, FLD_ACK_S, FLD_ACK_D, FLD_EOF, FLD_IFS
  } fld_e;
  localparam logic [6:0] LEN_ID_A = 7'd11;
  localparam logic [6:0] LEN_ID_B = 7'd18;
  localparam logic [6:0] LEN_CRC  = 7'd15;
  localparam logic [6:0] LEN_DLC  = 7'd4;
  function automatic logic [6:0] data_bits(input logic rtr, input logic [3:0] dlc);
    return rtr ? 7'd0 : dlc[3] ? 7'd64 : {1'b0, dlc[2:0], 3'b000};
  endfunction
endpackage

// File: rtl/can_frame_sequencer_counter.sv
// can_field_counter: loadable down-counter of bits remaining in the current field
module can_field_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       en,
  input  logic [6:0] len,
  output logic [6:0] cnt,
  output logic       last
);
  logic [6:0] cnt_q;
  // load wins over decrement; zero means unarmed and never wraps
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else if (load) cnt_q <= len;
    else if (en && cnt_q != '0) cnt_q <= cnt_q - 7'd1;
  assign cnt  = cnt_q;
  assign last = cnt_q == 7'd1;
endmodule

// File: rtl/can_frame_sequencer.sv
// can_frame_sequencer: tracks the field of the next sampled CAN bit and drives field strobes
module can_frame_sequencer
  import can_frame_sequencer_pkg::*;
#(
  parameter int INTEG_BITS = 11,
  parameter int EOF_BITS   = 7,
  parameter int IFS_BITS   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sp,
  input  logic       rx,
  input  logic       stuff_bit,
  input  logic       abort,
  output logic [4:0] field,
  output logic       f_crc_d,
  output logic       f_ack_d,
  output logic       f_ack_slot,
  output logic       f_eof,
  output logic       stuff_en,
  output logic       ide,
  output logic       rtr,
  output logic [3:0] dlc,
  output logic       frame_done,
  output logic       in_frame
);
  fld_e fld_q, fld_d, nxt;
  logic [6:0] bit_cnt, nxt_len, len;
  logic [3:0] dlc_q, dlc_d, dlc_shift;
  logic ide_q, ide_d, rtr_q, rtr_d, in_frame_d, done_d;
  logic cnt_last, load, en, adv, acc;
  assign acc       = sp && !(stuff_bit && stuff_en);
  assign dlc_shift = {dlc_q[2:0], rx};
  can_field_counter u_cnt (
    .clk(clk), .reset(reset), .load(load), .en(en), .len(len), .cnt(bit_cnt), .last(cnt_last)
  );
  // field successor of the current bit and whether this sample leaves the field
  always_comb begin
    nxt = FLD_INTEG;
    adv = cnt_last;
    case (fld_q)
      FLD_INTEG:   begin nxt = FLD_IDLE; adv = cnt_last && rx; end
      FLD_IDLE:    begin nxt = FLD_ID_A; adv = !rx; end
      FLD_ID_A:    nxt = FLD_RTR_SRR;
      FLD_RTR_SRR: nxt = FLD_IDE;
      FLD_IDE:     nxt = rx ? FLD_ID_B : FLD_R0;
      FLD_ID_B:    nxt = FLD_RTR_EXT;
      FLD_RTR_EXT: nxt = FLD_R1;
      FLD_R1:      nxt = FLD_R0;
      FLD_R0:      nxt = FLD_DLC;
      FLD_DLC:     nxt = data_bits(rtr_q, dlc_shift) != '0 ? FLD_DATA : FLD_CRC;
      FLD_DATA:    nxt = FLD_CRC;
      FLD_CRC:     nxt = FLD_CRC_D;
      FLD_CRC_D:   nxt = FLD_ACK_S;
      FLD_ACK_S:   nxt = FLD_ACK_D;
      FLD_ACK_D:   nxt = FLD_EOF;
      FLD_EOF:     nxt = FLD_IFS;
      FLD_IFS:     begin nxt = rx ? FLD_IDLE : cnt_last ? FLD_ID_A : FLD_INTEG; adv = cnt_last || !rx; end
      default:     adv = 1'b1;
    endcase
  end
  // length loaded into the counter on entry to the successor field
  always_comb
    case (nxt)
      FLD_ID_A:            nxt_len = LEN_ID_A;
      FLD_ID_B:            nxt_len = LEN_ID_B;
      FLD_DLC:             nxt_len = LEN_DLC;
      FLD_DATA:            nxt_len = data_bits(rtr_q, dlc_shift);
      FLD_CRC:             nxt_len = LEN_CRC;
      FLD_EOF:             nxt_len = 7'(EOF_BITS);
      FLD_IFS:             nxt_len = 7'(IFS_BITS);
      FLD_INTEG, FLD_IDLE: nxt_len = 7'd0;
      default:             nxt_len = 7'd1;
    endcase
  // commit the sample: abort first, then field advance or in-field counting and latching
  always_comb begin
    fld_d = fld_q;
    load = 1'b0;
    en = 1'b0;
    len = nxt_len;
    ide_d = ide_q;
    rtr_d = rtr_q;
    dlc_d = dlc_q;
    in_frame_d = in_frame;
    done_d = 1'b0;
    if (abort) begin
      fld_d = FLD_INTEG;
      load = 1'b1;
      len = 7'd0;
      in_frame_d = 1'b0;
    end else if (acc) begin
      if (adv) begin
        fld_d = nxt;
        load = 1'b1;
        in_frame_d = nxt == FLD_ID_A || (in_frame && fld_q != FLD_EOF);
        done_d = fld_q == FLD_EOF;
      end else if (fld_q == FLD_INTEG && !(rx && bit_cnt != '0)) begin
        load = 1'b1;
        len = rx ? 7'(INTEG_BITS - 1) : 7'd0;
      end else en = 1'b1;
      rtr_d = (fld_q == FLD_RTR_SRR || fld_q == FLD_RTR_EXT) ? rx : rtr_q;
      ide_d = fld_q == FLD_IDE ? rx : ide_q;
      dlc_d = fld_q == FLD_DLC ? dlc_shift : dlc_q;
    end
  end
  // state, latches and strobes decoded from the next field so they are registered
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      fld_q <= FLD_INTEG;
      ide_q <= 1'b0;
      rtr_q <= 1'b0;
      dlc_q <= '0;
      in_frame <= 1'b0;
      frame_done <= 1'b0;
      f_crc_d <= 1'b1;
      f_ack_d <= 1'b1;
      f_ack_slot <= 1'b0;
      f_eof <= 1'b0;
      stuff_en <= 1'b0;
    end else begin
      fld_q <= fld_d;
      ide_q <= ide_d;
      rtr_q <= rtr_d;
      dlc_q <= dlc_d;
      in_frame <= in_frame_d;
      frame_done <= done_d;
      f_crc_d <= fld_d != FLD_CRC_D;
      f_ack_d <= fld_d != FLD_ACK_D;
      f_ack_slot <= fld_d == FLD_ACK_S;
      f_eof <= fld_d == FLD_EOF;
      stuff_en <= fld_d >= FLD_ID_A && fld_d <= FLD_CRC;
    end
  assign field = fld_q;
  assign ide   = ide_q;
  assign rtr   = rtr_q;
  assign dlc   = dlc_q;
endmodule
